muldiv_ctrl: RTL
================

# muldiv_ctrl

Sequencer and owner of the architectural HI/LO registers. It sits beside the execute-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from it. Multiply and move-to-HI/LO commit in one cycle. Divide runs an iterative radix-2 restoring divider and stalls the pipeline until the result commits. Its HI/LO outputs drive the ALU's `hi_i`/`lo_i` inputs for MFHI/MFLO.

## Interface
- No parameters; datapath fixed at 32 bits, divide fixed at 32 iterations.
- `clk` in 1: single clock, all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `op_valid` in 1: execute-stage instruction valid this cycle.
- `sel` in 8: operation code, same `EXE_*_OP` encoding as the ALU. Only MULT, MULTU, DIV, DIVU, MTHI and MTLO are acted on; every other code is ignored.
- `a` in 32: rs operand (dividend / multiplicand / MTHI-MTLO source).
- `b` in 32: rt operand (divisor / multiplier).
- `flush` in 1: pipeline flush (exception/redirect); aborts the in-flight divide.
- `stall` out 1: hold execute stage and everything upstream.
- `busy` out 1: divider state is RUN or DONE.
- `hi_o` out 32: architectural HI register.
- `lo_o` out 32: architectural LO register.

## Operation
- Reset (`resetn` low, asynchronous): `hi_o`=0, `lo_o`=0, state=IDLE, iteration counter=0, `stall`=0, `busy`=0.
- States and transitions:
  - **IDLE → IDLE**: MULT, MULTU, MTHI, MTLO, or no op.
  - **IDLE → RUN**: `op_valid` and DIV/DIVU and not `flush`.
  - **RUN → DONE**: after the 32nd iteration.
  - **DONE → IDLE**: always.
  - **RUN/DONE → IDLE**: on `flush`.
- Accepted only when state is IDLE and `flush`=0; otherwise `op_valid` is ignored.
- **MULT**: `{hi,lo}` ← signed(a)×signed(b), full 64-bit product, written at the accepting edge.
- **MULTU**: `{hi,lo}` ← a×b, unsigned 64-bit, written at the accepting edge.
- **MTHI**: `hi` ← a; `lo` unchanged.
- **MTLO**: `lo` ← a; `hi` unchanged.
- **DIV/DIVU start**: latch |a| and |b| (unsigned for DIVU), plus quotient-sign = a[31]^b[31] and remainder-sign = a[31] (both 0 for DIVU). Clear the 33-bit partial remainder. Counter=0.
- **RUN, each cycle**:
  - Shift the remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor; if non-negative, keep the result and shift in quotient bit 1, else restore and shift in 0.
  - Counter increments; after counter=31 the state goes to DONE.
- **DONE**: `lo` ← quotient, negated if quotient-sign; `hi` ← remainder, negated if remainder-sign. Both are written at the DONE→IDLE edge.
- **Divide by zero**: no special path; runs full latency. Unsigned result is `hi`=a, `lo`=32'hFFFFFFFF. Signed result follows the same magnitude rules with the sign fix-up applied.
- **0x80000000 / 0xFFFFFFFF (DIV)**: `lo`=0x80000000, `hi`=0.
- **flush**:
  - In RUN or DONE: state → IDLE next edge, `hi`/`lo` untouched.
  - In IDLE: the coincident op is dropped (no HI/LO write).

## Timing
- `stall` is combinational: `stall` = (IDLE & `op_valid` & DIV/DIVU & ~`flush`) | (state==RUN & ~`flush`).
- `stall` is low in DONE, so the held divide instruction advances exactly once, in the DONE cycle. Its `op_valid` in that cycle is not re-accepted because state ≠ IDLE.
- **Divide latency**: accept cycle C0, RUN C1..C32, DONE C33. `stall` is high C0–C32 (33 cycles). `hi_o`/`lo_o` show the result from C34.
- **MULT/MULTU/MTHI/MTLO latency**: issued in cycle C, visible on `hi_o`/`lo_o` from C+1. No stall. A following MFHI in C+1 reads the new value.
- `busy` is registered from state: high C1–C33.
- **Reset mid-divide**: immediate IDLE, outputs as at reset, partial result discarded.

## Test plan
- **Reset**: assert `resetn`=0 mid-RUN → `stall`=0, `busy`=0, `hi_o`=`lo_o`=0 immediately, without waiting for a clock.
- **MULT/MULTU**:
  - MULT a=0xFFFFFFFE, b=3 → next cycle `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFFA.
  - MULTU with the same operands → `hi_o`=0x00000002, `lo_o`=0xFFFFFFFA.
- **DIVU**: a=100, b=7 → `stall` high exactly 33 cycles, then `lo_o`=14, `hi_o`=2.
- **Signed DIV**:
  - a=-7, b=2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0.
- **Divide by zero**: DIVU a=0x1234, b=0 → 33-cycle stall, `hi_o`=0x1234, `lo_o`=0xFFFFFFFF.
- **Flush**:
  - `flush` at RUN cycle 10 → `stall` low same cycle, IDLE next, HI/LO hold their prior MTHI/MTLO values.
  - MTLO with coincident `flush` → `lo_o` unchanged.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO register owner and multiply/divide sequencer beside the execute-stage ALU.
// Multiply and MTHI/MTLO commit in one cycle; divide is a 32-step restoring divider that stalls.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [7:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] dq;      // dividend bits shift out the top while quotient bits shift in
    logic [31:0] dvs;
    logic [32:0] rem;
    logic        qneg, rneg;

    logic        is_div, sdiv, accept;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] a_mag, b_mag, quot_fix, rem_fix;
    logic [32:0] rem_sh, trial;

    always_comb begin
        is_div   = (sel == EXE_DIV_OP) || (sel == EXE_DIVU_OP);
        sdiv     = (sel == EXE_DIV_OP);
        accept   = (state == IDLE) && op_valid && !flush;
        mul_a    = {{32{(sel == EXE_MULT_OP) & a[31]}}, a};
        mul_b    = {{32{(sel == EXE_MULT_OP) & b[31]}}, b};
        prod     = mul_a * mul_b;
        a_mag    = (sdiv && a[31]) ? -a : a;
        b_mag    = (sdiv && b[31]) ? -b : b;
        rem_sh   = {rem[31:0], dq[31]};
        trial    = rem_sh - {1'b0, dvs};
        quot_fix = qneg ? -dq : dq;
        rem_fix  = rneg ? -rem[31:0] : rem[31:0];
        // Gated by resetn so a held divide cannot assert stall while the block is in reset
        stall    = resetn && !flush &&
                   (((state == IDLE) && op_valid && is_div) || (state == RUN));
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            dq    <= '0;
            dvs   <= '0;
            rem   <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            hi_o  <= '0;
            lo_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (sel)
                            EXE_MULT_OP, EXE_MULTU_OP: {hi_o, lo_o} <= prod;
                            EXE_MTHI_OP: hi_o <= a;
                            EXE_MTLO_OP: lo_o <= a;
                            EXE_DIV_OP, EXE_DIVU_OP: begin
                                dq    <= a_mag;
                                dvs   <= b_mag;
                                rem   <= '0;
                                cnt   <= '0;
                                qneg  <= sdiv & (a[31] ^ b[31]);
                                rneg  <= sdiv & a[31];
                                state <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (!trial[32]) begin
                            rem <= trial;
                            dq  <= {dq[30:0], 1'b1};
                        end else begin
                            rem <= rem_sh;
                            dq  <= {dq[30:0], 1'b0};
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31)
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!flush) begin
                        lo_o <= quot_fix;
                        hi_o <= rem_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
